// File: rtl/cpu_package.sv
// Shared types and opcode constants for the RV32I multi-cycle control path.
// Imported by the main decoder and the control FSM.
package cpu_package;

  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5
  } instruction_type_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    TRAP      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4    = 2'd0,
    PC_PLUS_IMM = 2'd1,
    PC_ALU      = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_src_t;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'd0,
    ALU_FUNCT  = 2'd1,
    ALU_BRANCH = 2'd2
  } alu_op_sel_t;

  typedef enum logic [1:0] {
    TRAP_NONE         = 2'd0,
    TRAP_ILLEGAL      = 2'd1,
    TRAP_IMEM_TIMEOUT = 2'd2,
    TRAP_DMEM_TIMEOUT = 2'd3
  } trap_cause_t;

  // One-hot instruction class; all zero for anything this block cannot execute.
  typedef struct packed {
    logic op;
    logic opimm;
    logic load;
    logic store;
    logic branch;
    logic jalr;
  } instr_class_t;

endpackage

// File: rtl/main_decoder.sv
// Opcode decoder: immediate format for the immediate generator, legality,
// and the instruction class that steers the control FSM.
module main_decoder
  import cpu_package::*;
(
  input  logic [6:0]        opcode_i,
  output instruction_type_t instr_type_o,
  output logic              legal_o,
  output instr_class_t      class_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    instr_type_o = R_TYPE;
    legal_o      = 1'b0;
    class_o      = '0;
    case (opcode_i)
      OPC_OP: begin
        legal_o    = 1'b1;
        class_o.op = 1'b1;
      end
      OPC_OPIMM: begin
        instr_type_o  = I_TYPE;
        legal_o       = 1'b1;
        class_o.opimm = 1'b1;
      end
      OPC_LOAD: begin
        instr_type_o = I_TYPE;
        legal_o      = 1'b1;
        class_o.load = 1'b1;
      end
      OPC_JALR: begin
        instr_type_o = I_TYPE;
        legal_o      = 1'b1;
        class_o.jalr = 1'b1;
      end
      OPC_STORE: begin
        instr_type_o  = S_TYPE;
        legal_o       = 1'b1;
        class_o.store = 1'b1;
      end
      OPC_BRANCH: begin
        instr_type_o   = B_TYPE;
        legal_o        = 1'b1;
        class_o.branch = 1'b1;
      end
      // Upper-immediate and JAL formats are reported but not executed here.
      OPC_LUI, OPC_AUIPC: instr_type_o = U_TYPE;
      OPC_JAL:            instr_type_o = J_TYPE;
      default:            instr_type_o = R_TYPE;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle RV32I main control FSM: fetch/decode/execute/memory/writeback
// sequencing, datapath enables and selects, and memory handshake timeouts.
module control_unit
  import cpu_package::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instruction,
  output logic              imem_req,
  input  logic              imem_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ready,
  input  logic              branch_taken,
  output logic              ir_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              reg_write,
  output logic [1:0]        wb_src,
  output logic              alu_src_b,
  output logic [1:0]        alu_op_sel,
  output instruction_type_t instruction_type,
  output logic [1:0]        trap_cause,
  output logic              halted
);

  localparam int              CNT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  trap_cause_t        trap_cause_q, trap_cause_d;

  logic               dec_legal;
  instr_class_t       cls;
  logic [4:0]         rd;
  logic               wait_expired;
  logic               unused_instr_bits;

  logic               ex_alu_src_b;
  alu_op_sel_t        ex_alu_op;
  pc_src_t            pc_src_c;
  wb_src_t            wb_src_c;
  alu_op_sel_t        alu_op_c;

  main_decoder u_main_decoder (
    .opcode_i     (instruction[6:0]),
    .instr_type_o (instruction_type),
    .legal_o      (dec_legal),
    .class_o      (cls)
  );

  assign rd                = instruction[11:7];
  assign unused_instr_bits = ^instruction[31:12];
  assign wait_expired      = TIMEOUT_EN && (wait_cnt_q == WAIT_LIMIT);

  // ALU operand/operation choice is a pure function of the class and is held
  // from EXECUTE through the end of the instruction.
  assign ex_alu_src_b = !(cls.op || cls.branch);
  assign ex_alu_op    = (cls.op || cls.opimm) ? ALU_FUNCT :
                        cls.branch            ? ALU_BRANCH : ALU_ADD;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments; reset is asynchronous so outputs drop at once.
    if (!rst_n) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      trap_cause_q <= TRAP_NONE;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    trap_cause_d = trap_cause_q;
    imem_req     = 1'b0;
    ir_write     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    pc_write     = 1'b0;
    pc_src_c     = PC_PLUS4;
    reg_write    = 1'b0;
    wb_src_c     = WB_ALU;
    alu_src_b    = 1'b0;
    alu_op_c     = ALU_ADD;

    unique case (state_q)
      IDLE: begin
        state_d    = FETCH;
        wait_cnt_d = '0;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = DECODE;
        end else if (wait_expired) begin
          state_d      = TRAP;
          trap_cause_d = TRAP_IMEM_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      DECODE: begin
        if (!dec_legal) begin
          state_d      = TRAP;
          trap_cause_d = TRAP_ILLEGAL;
        end else begin
          state_d = EXECUTE;
        end
      end

      EXECUTE: begin
        alu_src_b = ex_alu_src_b;
        alu_op_c  = ex_alu_op;
        if (cls.branch) begin
          pc_write   = 1'b1;
          pc_src_c   = branch_taken ? PC_PLUS_IMM : PC_PLUS4;
          state_d    = FETCH;
          wait_cnt_d = '0;
        end else if (cls.load || cls.store) begin
          state_d    = MEMORY;
          wait_cnt_d = '0;
        end else begin
          state_d = WRITEBACK;
        end
      end

      MEMORY: begin
        dmem_req  = 1'b1;
        dmem_we   = cls.store;
        alu_src_b = ex_alu_src_b;
        alu_op_c  = ex_alu_op;
        if (dmem_ready) begin
          if (cls.store) begin
            pc_write   = 1'b1;
            state_d    = FETCH;
            wait_cnt_d = '0;
          end else begin
            state_d = WRITEBACK;
          end
        end else if (wait_expired) begin
          state_d      = TRAP;
          trap_cause_d = TRAP_DMEM_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      WRITEBACK: begin
        alu_src_b  = ex_alu_src_b;
        alu_op_c   = ex_alu_op;
        reg_write  = (rd != 5'd0);
        wb_src_c   = cls.load ? WB_MEM : (cls.jalr ? WB_PC4 : WB_ALU);
        pc_write   = 1'b1;
        pc_src_c   = cls.jalr ? PC_ALU : PC_PLUS4;
        state_d    = FETCH;
        wait_cnt_d = '0;
      end

      TRAP: state_d = TRAP;

      default: state_d = IDLE;
    endcase
  end

  assign pc_src     = pc_src_c;
  assign wb_src     = wb_src_c;
  assign alu_op_sel = alu_op_c;
  assign trap_cause = trap_cause_q;
  assign halted     = (state_q == TRAP);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed instructions followed by
// randomized instructions, wait states, timeouts and mid-instruction resets.
module tb_control_unit;
  import cpu_package::*;

  localparam int TMO       = 4;
  localparam int TRAP_HOLD = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       instruction;
  logic              imem_req, imem_ready;
  logic              dmem_req, dmem_we, dmem_ready;
  logic              branch_taken;
  logic              ir_write, pc_write, reg_write;
  logic [1:0]        pc_src, wb_src, alu_op_sel, trap_cause;
  logic              alu_src_b, halted;
  instruction_type_t instruction_type;

  always #5 clk = ~clk;

  control_unit #(.MEM_TIMEOUT(TMO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instruction      (instruction),
    .imem_req         (imem_req),
    .imem_ready       (imem_ready),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_ready       (dmem_ready),
    .branch_taken     (branch_taken),
    .ir_write         (ir_write),
    .pc_write         (pc_write),
    .pc_src           (pc_src),
    .reg_write        (reg_write),
    .wb_src           (wb_src),
    .alu_src_b        (alu_src_b),
    .alu_op_sel       (alu_op_sel),
    .instruction_type (instruction_type),
    .trap_cause       (trap_cause),
    .halted           (halted)
  );

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] wb_src;
    logic       alu_src_b;
    logic [1:0] alu_op_sel;
    logic       halted;
    logic [1:0] trap_cause;
  } obs_t;

  typedef enum int {PH_FETCH, PH_DECODE, PH_EXECUTE, PH_MEMORY, PH_WRITEBACK, PH_TRAP} phase_t;

  typedef struct {
    logic   imem_ready;
    logic   dmem_ready;
    logic   branch_taken;
    obs_t   exp;
    obs_t   mask;
    phase_t phase;
  } step_t;

  obs_t  obs;
  step_t q[$];
  int    checks = 0;
  int    errors = 0;

  assign obs = {imem_req, ir_write, dmem_req, dmem_we, pc_write, pc_src, reg_write,
                wb_src, alu_src_b, alu_op_sel, halted, trap_cause};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference decode straight from the opcode table.
  function automatic instruction_type_t ref_type(input logic [31:0] ins);
    case (ins[6:0])
      OPC_OP:                       return R_TYPE;
      OPC_OPIMM, OPC_LOAD, OPC_JALR: return I_TYPE;
      OPC_STORE:                    return S_TYPE;
      OPC_BRANCH:                   return B_TYPE;
      OPC_LUI, OPC_AUIPC:           return U_TYPE;
      OPC_JAL:                      return J_TYPE;
      default:                      return R_TYPE;
    endcase
  endfunction

  function automatic obs_t ctl_mask();
    obs_t m;
    m            = '1;
    m.pc_src     = '0;
    m.wb_src     = '0;
    m.alu_src_b  = 1'b0;
    m.alu_op_sel = '0;
    return m;
  endfunction

  function automatic logic noise();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(input phase_t ph, input logic ir, input logic dr, input logic bt,
                      input obs_t e, input obs_t m);
    q.push_back('{imem_ready: ir, dmem_ready: dr, branch_taken: bt, exp: e, mask: m, phase: ph});
  endtask

  task automatic push_trap(input logic [1:0] cause);
    obs_t e;
    for (int k = 0; k < TRAP_HOLD; k++) begin
      e            = '0;
      e.halted     = 1'b1;
      e.trap_cause = cause;
      push(PH_TRAP, noise(), noise(), noise(), e, '1);
    end
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, starting in FETCH.
  task automatic build(input logic [31:0] ins, input int iw, input int dw, input logic bt,
                       output bit trapped);
    obs_t e, m;
    logic [6:0] opc;
    bit is_op, is_opimm, is_load, is_store, is_branch, is_jalr, legal;
    logic exp_src_b;
    logic [1:0] exp_alu;
    opc       = ins[6:0];
    is_op     = (opc == OPC_OP);
    is_opimm  = (opc == OPC_OPIMM);
    is_load   = (opc == OPC_LOAD);
    is_store  = (opc == OPC_STORE);
    is_branch = (opc == OPC_BRANCH);
    is_jalr   = (opc == OPC_JALR);
    legal     = is_op || is_opimm || is_load || is_store || is_branch || is_jalr;
    exp_src_b = (is_op || is_branch) ? 1'b0 : 1'b1;
    exp_alu   = (is_op || is_opimm) ? 2'd1 : (is_branch ? 2'd2 : 2'd0);
    trapped   = 1'b0;

    for (int k = 0; k < TMO && k <= iw; k++) begin
      e          = '0;
      e.imem_req = 1'b1;
      e.ir_write = (k == iw);
      push(PH_FETCH, (k == iw), noise(), noise(), e, ctl_mask());
    end
    if (iw >= TMO) begin
      push_trap(2'd2);
      trapped = 1'b1;
      return;
    end

    push(PH_DECODE, noise(), noise(), noise(), '0, ctl_mask());
    if (!legal) begin
      push_trap(2'd1);
      trapped = 1'b1;
      return;
    end

    e            = '0;
    m            = ctl_mask();
    e.alu_src_b  = exp_src_b;
    e.alu_op_sel = exp_alu;
    m.alu_src_b  = 1'b1;
    m.alu_op_sel = '1;
    if (is_branch) begin
      e.pc_write = 1'b1;
      e.pc_src   = bt ? 2'd1 : 2'd0;
      m.pc_src   = '1;
      push(PH_EXECUTE, noise(), noise(), bt, e, m);
      return;
    end
    push(PH_EXECUTE, noise(), noise(), noise(), e, m);

    if (is_load || is_store) begin
      for (int k = 0; k < TMO && k <= dw; k++) begin
        e            = '0;
        m            = ctl_mask();
        e.dmem_req   = 1'b1;
        e.dmem_we    = is_store;
        e.alu_src_b  = exp_src_b;
        e.alu_op_sel = exp_alu;
        m.alu_src_b  = 1'b1;
        m.alu_op_sel = '1;
        if (k == dw && is_store) begin
          e.pc_write = 1'b1;
          m.pc_src   = '1;
        end
        push(PH_MEMORY, noise(), (k == dw), noise(), e, m);
      end
      if (dw >= TMO) begin
        push_trap(2'd3);
        trapped = 1'b1;
        return;
      end
      if (is_store) return;
    end

    e           = '0;
    m           = ctl_mask();
    e.reg_write = (ins[11:7] != 5'd0);
    e.wb_src    = is_load ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
    e.pc_write  = 1'b1;
    e.pc_src    = is_jalr ? 2'd2 : 2'd0;
    m.wb_src    = '1;
    m.pc_src    = '1;
    if (is_jalr) begin
      e.alu_src_b  = 1'b1;
      e.alu_op_sel = 2'd0;
      m.alu_src_b  = 1'b1;
      m.alu_op_sel = '1;
    end
    push(PH_WRITEBACK, noise(), noise(), noise(), e, m);
  endtask

  task automatic do_reset();
    // NOTE: bench inputs are driven with blocking assignments away from the clock edge.
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    #2;
    check("reset_outputs_zero", 32'(obs), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_outputs_zero", 32'(obs), 32'h0);
  endtask

  task automatic run(input logic [31:0] ins, input int iw, input int dw, input logic bt,
                     input int abort_at);
    bit trapped;
    q.delete();
    build(ins, iw, dw, bt, trapped);
    foreach (q[i]) begin
      @(negedge clk);
      instruction  = ins;
      imem_ready   = q[i].imem_ready;
      dmem_ready   = q[i].dmem_ready;
      branch_taken = q[i].branch_taken;
      #1;
      check($sformatf("%s[%0d] ins=0x%08h", q[i].phase.name(), i, ins),
            32'(obs & q[i].mask), 32'(q[i].exp & q[i].mask));
      check($sformatf("type[%0d] ins=0x%08h", i, ins),
            32'(instruction_type), 32'(ref_type(ins)));
      if (i == abort_at) begin
        do_reset();
        return;
      end
    end
    if (trapped) do_reset();
  endtask

  logic [6:0] pool [14];

  initial begin
    logic [31:0] ins;
    int          iw, dw, abort_at;
    pool = '{OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR,
             OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR,
             OPC_LUI, OPC_JAL};
    instruction  = 32'h0;
    imem_ready   = 1'b0;
    dmem_ready   = 1'b0;
    branch_taken = 1'b0;
    do_reset();

    run(32'h00500093, 0, 0, 1'b0, -1);   // ADDI x1,x0,5
    run(32'h0020A223, 0, 0, 1'b0, -1);   // SW x2,4(x1)
    run(32'h00208463, 0, 0, 1'b1, -1);   // BEQ taken
    run(32'h00208463, 0, 0, 1'b0, -1);   // BEQ not taken
    run(32'h0000A183, 0, 3, 1'b0, -1);   // LW, ready on 4th request cycle
    run(32'h000080E7, 1, 0, 1'b0, -1);   // JALR x1,0(x1)
    run(32'h00008067, 0, 0, 1'b0, -1);   // JALR x0 -> no register write
    run(32'h00000013, 2, 0, 1'b0, -1);   // ADDI x0 -> no register write
    run(32'h0000007F, 0, 0, 1'b0, -1);   // illegal opcode
    run(32'h00000037, 0, 0, 1'b0, -1);   // LUI is illegal here
    run(32'h00500093, TMO, 0, 1'b0, -1); // fetch timeout
    run(32'h00500093, TMO - 1, 0, 1'b0, -1);
    run(32'h0000A183, 2, TMO, 1'b0, -1); // data timeout
    run(32'h0020A223, 0, 1, 1'b0, 3);    // reset during MEMORY

    for (int n = 0; n < 200; n++) begin
      ins = $urandom();
      if ($urandom_range(0, 19) == 0) ins[6:0] = 7'($urandom());
      else ins[6:0] = pool[$urandom_range(0, 13)];
      iw       = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, TMO - 1);
      dw       = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, TMO - 1);
      abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1;
      run(ins, iw, dw, logic'($urandom_range(0, 1)), abort_at);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
